// File: rtl/hls_macc_param_obf.sv
// hls_macc_param_obf: key-locked serial N-term multiply-accumulate with ap_start/ap_done handshake.
// Define MACC_SAT_EN for a saturating accumulate with a sticky o1_ovf; otherwise it wraps and o1_ovf=0.
module hls_macc_param_obf #(
    parameter int DATA_W  = 32,
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 32,
    parameter int KEY_W   = 3071,
    parameter int KEY_OFS = 0
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst,
    input  logic                        ap_start,
    output logic                        ap_done,
    output logic                        ap_idle,
    output logic                        ap_ready,
    input  logic [N_TERMS*DATA_W-1:0]   a_data,
    input  logic [N_TERMS*DATA_W-1:0]   b_data,
    input  logic [DATA_W-1:0]           bias,
    output logic [ACC_W-1:0]            o1,
    output logic                        o1_ap_vld,
    output logic                        o1_ovf,
    input  logic [KEY_W-1:0]            locking_key
);
    localparam int WK_W  = 2 * N_TERMS + 1;
    localparam int IDX_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        MAC  = 4'b0010,
        FIN  = 4'b0100,
        DONE = 4'b1000
    } state_t;

    state_t                     state, next_state;
    logic signed [DATA_W-1:0]   a_reg [N_TERMS];
    logic signed [DATA_W-1:0]   b_reg [N_TERMS];
    logic                       mul_key [N_TERMS];
    logic                       add_key [N_TERMS];
    logic                       fin_key;
    logic signed [ACC_W-1:0]    acc;
    logic [IDX_W-1:0]           idx;
    logic [ACC_W-1:0]           o1_reg;
    logic                       ovf;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [DATA_W:0]     sum;
    logic signed [ACC_W-1:0]    p;
    logic [ACC_W:0]             acc_next;
    logic                       last;
    logic [WK_W-1:0]            wk;
    logic                       unused_key;

    // Returns {clamped, result}; clamped is always 0 in the wrapping build.
    function automatic logic [ACC_W:0] accumulate(input logic signed [ACC_W-1:0] x,
                                                  input logic signed [ACC_W-1:0] y,
                                                  input logic add);
`ifdef MACC_SAT_EN
        logic signed [ACC_W:0] r;
        r = add ? ((ACC_W+1)'(x) + (ACC_W+1)'(y)) : ((ACC_W+1)'(x) - (ACC_W+1)'(y));
        if (r[ACC_W] != r[ACC_W-1])
            return r[ACC_W] ? {1'b1, 1'b1, {(ACC_W-1){1'b0}}} : {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
        return {1'b0, r[ACC_W-1:0]};
`else
        logic [ACC_W-1:0] r;
        r = add ? (x + y) : (x - y);
        return {1'b0, r};
`endif
    endfunction

    assign wk         = locking_key[KEY_OFS +: WK_W];
    assign unused_key = ^locking_key;
    assign last       = (idx == IDX_W'(N_TERMS - 1));
    assign o1         = o1_reg;
    assign o1_ovf     = ovf;

    always_comb begin
        prod     = (2*DATA_W)'(a_reg[idx]) * (2*DATA_W)'(b_reg[idx]);
        sum      = (DATA_W+1)'(a_reg[idx]) + (DATA_W+1)'(b_reg[idx]);
        p        = mul_key[idx] ? ACC_W'(prod) : ACC_W'(sum);
        acc_next = accumulate(acc, p, add_key[idx]);
    end

    always_comb begin
        next_state = IDLE;
        ap_done    = 1'b0;
        ap_ready   = 1'b0;
        o1_ap_vld  = 1'b0;
        ap_idle    = 1'b0;
        case (state)
            IDLE: begin
                ap_idle    = !ap_start;
                next_state = ap_start ? MAC : IDLE;
            end
            MAC:  next_state = last ? FIN : MAC;
            FIN:  next_state = DONE;
            DONE: begin
                ap_done    = 1'b1;
                ap_ready   = 1'b1;
                o1_ap_vld  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand/key capture: the run works only from these copies, so later input changes are harmless.
    always_ff @(posedge ap_clk) begin
        if (state == IDLE && ap_start) begin
            for (int i = 0; i < N_TERMS; i++) begin
                a_reg[i]   <= a_data[i*DATA_W +: DATA_W];
                b_reg[i]   <= b_data[i*DATA_W +: DATA_W];
                mul_key[i] <= wk[2*i];
                add_key[i] <= wk[2*i+1];
            end
            fin_key <= wk[2*N_TERMS];
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state  <= IDLE;
            acc    <= '0;
            idx    <= '0;
            o1_reg <= '0;
            ovf    <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: if (ap_start) begin
                    acc <= ACC_W'($signed(bias));
                    idx <= '0;
                    ovf <= 1'b0;
                end
                MAC: begin
                    acc <= acc_next[ACC_W-1:0];
                    ovf <= ovf | acc_next[ACC_W];
                    if (!last) idx <= idx + IDX_W'(1);
                end
                FIN:     o1_reg <= fin_key ? acc : ~acc;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hls_macc_param_obf.sv
// Self-checking bench for hls_macc_param_obf against a plain-arithmetic reference model.
module tb_hls_macc_param_obf;
    localparam int DATA_W  = 32;
    localparam int N_TERMS = 4;
    localparam int ACC_W   = 32;
    localparam int KEY_W   = 3071;
    localparam int KEY_OFS = 0;
    localparam int WK_W    = 2 * N_TERMS + 1;
    localparam int VW      = N_TERMS * DATA_W;

    logic              ap_clk = 1'b0;
    logic              ap_rst, ap_start;
    logic              ap_done, ap_idle, ap_ready, o1_ap_vld, o1_ovf;
    logic [VW-1:0]     a_data, b_data;
    logic [DATA_W-1:0] bias;
    logic [ACC_W-1:0]  o1;
    logic [KEY_W-1:0]  locking_key;
    int total = 0;
    int bad   = 0;

    hls_macc_param_obf #(.DATA_W(DATA_W), .N_TERMS(N_TERMS), .ACC_W(ACC_W),
                         .KEY_W(KEY_W), .KEY_OFS(KEY_OFS)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_done(ap_done),
        .ap_idle(ap_idle), .ap_ready(ap_ready), .a_data(a_data), .b_data(b_data),
        .bias(bias), .o1(o1), .o1_ap_vld(o1_ap_vld), .o1_ovf(o1_ovf),
        .locking_key(locking_key));

    always #5 ap_clk = ~ap_clk;

    function automatic longint wrap(input longint x);
        logic signed [ACC_W-1:0] t;
        t = x[ACC_W-1:0];
        return longint'(t);
    endfunction

    // Reference: returns {ovf, o1} computed term by term with 64-bit integers.
    function automatic logic [ACC_W:0] model(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                             input logic [DATA_W-1:0] bi, input logic [WK_W-1:0] wk);
        longint acc, p, x, y;
        longint maxv, minv;
        logic ovf;
        logic [ACC_W-1:0] r;
        logic signed [DATA_W-1:0] sa, sb, sbias;
        maxv = (longint'(1) <<< (ACC_W - 1)) - 1;
        minv = -(longint'(1) <<< (ACC_W - 1));
        ovf = 1'b0;
        sbias = bi;
        acc = longint'(sbias);
        for (int i = 0; i < N_TERMS; i++) begin
            sa = a[i*DATA_W +: DATA_W];
            sb = b[i*DATA_W +: DATA_W];
            x = longint'(sa);
            y = longint'(sb);
            p = wrap(wk[2*i] ? x * y : x + y);
            acc = wk[2*i+1] ? acc + p : acc - p;
`ifdef MACC_SAT_EN
            if (acc > maxv) begin acc = maxv; ovf = 1'b1; end
            else if (acc < minv) begin acc = minv; ovf = 1'b1; end
`else
            acc = wrap(acc);
`endif
        end
        r = acc[ACC_W-1:0];
        if (!wk[2*N_TERMS]) r = ~r;
        return {ovf, r};
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < N_TERMS; i++) v[i*DATA_W +: DATA_W] = $urandom;
        return v;
    endfunction

    task automatic set_key(input logic [WK_W-1:0] wk);
        for (int i = 0; i < KEY_W; i++) locking_key[i] = 1'($urandom);
        locking_key[KEY_OFS +: WK_W] = wk;
    endtask

    // One start pulse; inputs and key are scrambled every cycle after capture.
    task automatic run_one(input string name, input logic [VW-1:0] a, input logic [VW-1:0] b,
                           input logic [DATA_W-1:0] bi, input logic [WK_W-1:0] wk,
                           input logic [ACC_W:0] expv);
        @(negedge ap_clk);
        a_data = a; b_data = b; bias = bi; set_key(wk); ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) @(negedge ap_clk);
            total++;
            if (ap_done !== (k == 6) || ap_ready !== (k == 6) || o1_ap_vld !== (k == 6)) begin
                bad++;
                $display("FAIL %s handshake cycle %0d: done=%b ready=%b vld=%b required=%b",
                         name, k, ap_done, ap_ready, o1_ap_vld, (k == 6));
            end
            if (k == 6) begin
                total++;
                if ({o1_ovf, o1} !== expv) begin
                    bad++;
                    $display("FAIL %s result: ovf=%b o1=%h required ovf=%b o1=%h",
                             name, o1_ovf, o1, expv[ACC_W], expv[ACC_W-1:0]);
                end
            end
            if (k == 7) begin
                total++;
                if (ap_idle !== 1'b1) begin
                    bad++;
                    $display("FAIL %s idle after done: ap_idle=%b required=1", name, ap_idle);
                end
            end
            if (k <= 5) begin
                a_data = rand_vec(); b_data = rand_vec(); bias = $urandom;
                set_key(WK_W'($urandom));
            end
        end
    endtask

    task automatic test_reset();
        ap_rst = 1'b1; ap_start = 1'b0; a_data = '0; b_data = '0; bias = '0; locking_key = '0;
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        total++;
        if (o1 !== '0 || o1_ovf !== 1'b0 || ap_done !== 1'b0 || ap_ready !== 1'b0 ||
            o1_ap_vld !== 1'b0 || ap_idle !== 1'b1) begin
            bad++;
            $display("FAIL reset: o1=%h ovf=%b done=%b ready=%b vld=%b idle=%b required 0/0/0/0/0/1",
                     o1, o1_ovf, ap_done, ap_ready, o1_ap_vld, ap_idle);
        end
        ap_rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [VW-1:0] a, b;
        a = {32'd4, 32'd3, 32'd2, 32'd1};
        b = {32'd8, 32'd7, 32'd6, 32'd5};
        run_one("mac_all_ones", a, b, 32'd10, '1, {1'b0, 32'd80});
        run_one("wrong_key_zero", a, b, 32'd10, '0, {1'b0, 32'd25});
        a = {32'd0, 32'd0, 32'd0, 32'd16};
        b = {32'd0, 32'd0, 32'd0, 32'd1};
`ifdef MACC_SAT_EN
        run_one("overflow", a, b, 32'h7FFFFFF0, '1, {1'b1, 32'h7FFFFFFF});
`else
        run_one("overflow", a, b, 32'h7FFFFFF0, '1, {1'b0, 32'h80000000});
`endif
    endtask

    task automatic test_random();
        logic [VW-1:0] a, b;
        logic [DATA_W-1:0] bi;
        logic [WK_W-1:0] wk;
        for (int n = 0; n < 12; n++) begin
            a = rand_vec(); b = rand_vec(); bi = $urandom; wk = WK_W'($urandom);
            if (n % 3 == 0) begin
                for (int i = 0; i < N_TERMS; i++) begin
                    a[i*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 300)) - 32'd150;
                    b[i*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 300)) - 32'd150;
                end
            end
            run_one("random", a, b, bi, wk, model(a, b, bi, wk));
        end
    endtask

    task automatic test_key_toggle();
        logic [VW-1:0] a, b;
        a = rand_vec(); b = rand_vec();
        run_one("key_toggle", a, b, 32'd7, 9'b101100110, model(a, b, 32'd7, 9'b101100110));
    endtask

    task automatic test_reset_mid_run();
        logic [VW-1:0] a, b;
        a = {32'd4, 32'd3, 32'd2, 32'd1};
        b = {32'd8, 32'd7, 32'd6, 32'd5};
        run_one("pre_reset_run", a, b, 32'd10, '1, {1'b0, 32'd80});
        @(negedge ap_clk);
        a_data = rand_vec(); b_data = rand_vec(); set_key('1); ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        repeat (2) @(negedge ap_clk);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        total++;
        if (ap_idle !== 1'b1 || o1 !== '0 || o1_ovf !== 1'b0 || ap_done !== 1'b0) begin
            bad++;
            $display("FAIL mid_run_reset: idle=%b o1=%h ovf=%b done=%b required 1/0/0/0",
                     ap_idle, o1, o1_ovf, ap_done);
        end
        ap_rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge ap_clk);
            total++;
            if (ap_done !== 1'b0) begin
                bad++;
                $display("FAIL discarded_run_done: cycle %0d done=%b required=0", k, ap_done);
            end
        end
        run_one("after_reset", a, b, 32'd10, '1, {1'b0, 32'd80});
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] a [3];
        logic [VW-1:0] b;
        logic [DATA_W-1:0] bi;
        logic [WK_W-1:0] wk;
        logic [ACC_W:0] expv [3];
        int r;
        b = rand_vec(); bi = $urandom; wk = WK_W'($urandom);
        for (int i = 0; i < 3; i++) begin
            a[i] = rand_vec();
            expv[i] = model(a[i], b, bi, wk);
        end
        @(negedge ap_clk);
        a_data = a[0]; b_data = b; bias = bi; set_key(wk); ap_start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge ap_clk);
            r = (k - 6) / 7;
            total++;
            if (ap_done !== (k % 7 == 6) || ap_idle !== 1'b0) begin
                bad++;
                $display("FAIL back_to_back handshake cycle %0d: done=%b idle=%b required done=%b idle=0",
                         k, ap_done, ap_idle, (k % 7 == 6));
            end
            if (k % 7 == 6) begin
                total++;
                if ({o1_ovf, o1} !== expv[r]) begin
                    bad++;
                    $display("FAIL back_to_back run %0d: o1=%h ovf=%b required o1=%h ovf=%b",
                             r, o1, o1_ovf, expv[r][ACC_W-1:0], expv[r][ACC_W]);
                end
            end
            if (k == 1) a_data = a[1];
            if (k == 8) a_data = a[2];
            if (k == 20) ap_start = 1'b0;
        end
        @(negedge ap_clk);
        total++;
        if (ap_idle !== 1'b1) begin
            bad++;
            $display("FAIL back_to_back idle at end: ap_idle=%b required=1", ap_idle);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_key_toggle();
        test_reset_mid_run();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
